mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
MEM-stage load/store unit of the 5-stage RV32I pipeline, directly downstream of the EX/MEM register. Consumes the EX/MEM outputs: ALU address, store data, funct3 and control bits. Runs a req/gnt/rvalid handshake to the data memory, stalls the pipeline while an access is outstanding, and aligns and sign-extends load data. Registers the MEM/WB results for the writeback stage.

Parameters:
TIMEOUT_CYCLES, 255, cycles without gnt/rvalid before the access is aborted with bus_err_o
XLEN, 32, data/address width; only 32 is supported

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_valid  in  1  valid instruction in MEM
mem_addr  in  32  effective address (EX/MEM ALU_out)
mem_wdata  in  32  store data, rs2 forwarded
mem_funct3  in  3  access size/sign: LB/LH/LW/LBU/LHU, SB/SH/SW
mem_read  in  1  load
mem_write  in  1  store
mem_regwrite  in  1  instruction writes rd
mem_memtoreg  in  1  rd gets load data, else mem_addr (ALU result)
mem_rd  in  5  destination register
dmem_req  out  1  access request
dmem_we  out  1  write enable
dmem_addr  out  32  word-aligned address {mem_addr[31:2],2'b00}
dmem_wstrb  out  4  byte strobes
dmem_wdata  out  32  store data replicated to lanes
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid (loads only)
dmem_rdata  in  32  read data word
stall_o  out  1  hold IF..MEM, insert bubble into WB
misalign_o  out  1  one-cycle pulse on misaligned access
bus_err_o  out  1  one-cycle pulse on timeout abort
wb_valid  out  1  MEM/WB valid
wb_regwrite  out  1  MEM/WB regwrite
wb_rd  out  5  MEM/WB rd
wb_data  out  32  MEM/WB writeback value

Behaviour:
- Reset (async): state=IDLE, timeout counter=0. wb_valid, wb_regwrite, wb_rd, wb_data, misalign_o and bus_err_o are all 0. dmem_req=0 while in reset.
- access = mem_valid & (mem_read|mem_write) & ~misaligned. mem_read and mem_write both set counts as a load.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. No request is issued. misalign_o pulses for one cycle. WB entry is written with wb_valid=1 and wb_regwrite=0. No stall.
- Non-memory instruction: one-cycle pass-through. wb_data=mem_addr. The wb_* outputs are registered on the next clk edge.
- Store lanes:
  - SB: wdata={4{b}}, wstrb=1<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=addr[1]?4'b1100:4'b0011.
  - SW: wstrb=4'hF.
  - Loads: dmem_we=0, wstrb=0.
- FSM states: IDLE, REQ, RESP.
  - IDLE: if access, dmem_req=1 combinationally. On gnt: a store is done this cycle; a load goes to RESP. Without gnt, go to REQ.
  - REQ: dmem_req held at 1, address/data stable. On gnt: a store is done and goes to IDLE; a load goes to RESP.
  - RESP: dmem_req=0. On rvalid, the load is done and goes to IDLE.
  - rvalid arriving in the same cycle as gnt is illegal, because memory latency is at least 1.
- stall_o = access & ~done_this_cycle. Upstream holds the mem_* inputs stable while stall_o=1.
- Done cycle: the MEM/WB register captures the result at the clk edge. While stalled, the MEM/WB register captures a bubble (wb_valid=0, wb_regwrite=0).
- Load data: byte/half selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. wb_data = extracted value when mem_memtoreg, else mem_addr.
- Minimum latencies:
  - Store with gnt in the first cycle: 0 stall cycles.
  - Load with gnt in cycle 0 and rvalid in cycle 1: 1 stall cycle; wb_* valid after the cycle-1 edge.
- Timeout: the counter increments in REQ and RESP and clears on IDLE entry. On reaching TIMEOUT_CYCLES-1:
  - go to IDLE and pulse bus_err_o;
  - write WB with wb_regwrite=0;
  - drop stall_o;
  - ignore any late rvalid until the next request is granted.
- A reset mid-access drops dmem_req immediately. The memory side treats this as a cancel.
- x0 handling: wb_regwrite is forced to 0 when mem_rd=0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - the lsu_state_e enum {IDLE, REQ, RESP};
  - a mem_wb_t struct for the WB bundle.
- One combinational sub-module, load_align: inputs rdata, addr[1:0], funct3; output the 32-bit extended value. It is unit-tested separately.

Test Plan:
- SB x5=0x000000A5 to addr 0x1003, gnt in the first cycle -> wstrb=4'b1000, wdata=0xA5A5A5A5, dmem_addr=0x1000, stall_o=0 for 0 cycles.
- LB from 0x2001, rdata=0x12348056, gnt in cycle 0, rvalid in cycle 1 -> stall_o high 1 cycle; wb_data=0x00000080 is wrong, required wb_data=0xFFFFFF80 (byte 0x80 sign-extended); LBU gives 0x00000080.
- LH from 0x3002, gnt delayed 3 cycles, rvalid 2 cycles later -> stall_o high 5 cycles, dmem_req high 4 cycles; with rdata=0xBEEF0000, wb_data=0xFFFFBEEF.
- LW from 0x4001 -> misalign_o pulse, no dmem_req, wb_valid=1 with wb_regwrite=0, no stall.
- Load granted, rvalid never arrives (TIMEOUT_CYCLES=8) -> bus_err_o pulse 8 cycles after entering RESP, stall released, wb_regwrite=0.
- Reset asserted in RESP -> dmem_req=0, all wb_* outputs 0 immediately; the next ADD passes through with wb_data=mem_addr after one edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
//   - funct3 encodings for the RV32I load/store sizes
//   - lsu_state_e : memory handshake state machine encoding
//   - mem_wb_t    : MEM/WB pipeline register bundle
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic        valid;
      logic        regwrite;
      logic [4:0]  rd;
      logic [31:0] data;
   } mem_wb_t;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// load_align: combinational load data extraction.
// Picks the byte/halfword addressed by addr[1:0] out of the 32-bit read
// word and sign- or zero-extends it according to funct3.
//   rdata  in  32  read data word from memory
//   addr   in  2   low address bits (byte offset in word)
//   funct3 in  3   load size/sign (LB/LH/LW/LBU/LHU)
//   value  out 32  extended load value
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      // Halfword accesses are always aligned here, so only addr[1] matters.
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    value = {{16{half_sel[15]}}, half_sel};
         F3_BU:   value = {24'd0, byte_sel};
         F3_HU:   value = {16'd0, half_sel};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit of the 5-stage RV32I pipeline.
// Takes the EX/MEM outputs, runs a req/gnt/rvalid handshake to data memory,
// stalls the pipeline while an access is outstanding, aligns load data and
// registers the MEM/WB bundle.
//   clk, reset                 clock, async active-high reset
//   mem_*                      instruction currently in MEM (held while stall_o)
//   dmem_req/we/addr/wstrb/wdata  request side to data memory
//   dmem_gnt/rvalid/rdata      memory responses
//   stall_o                    hold IF..MEM, bubble into WB
//   misalign_o, bus_err_o      one-cycle registered event pulses
//   wb_*                       MEM/WB register outputs
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int XLEN           = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            mem_valid,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic [2:0]      mem_funct3,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            mem_regwrite,
   input  logic            mem_memtoreg,
   input  logic [4:0]      mem_rd,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_wstrb,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall_o,
   output logic            misalign_o,
   output logic            bus_err_o,
   output logic            wb_valid,
   output logic            wb_regwrite,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data
);

   // Counter can step once past TIMEOUT_CYCLES-1 when a grant lands on the
   // last REQ cycle, so it needs room for TIMEOUT_CYCLES itself.
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mem_wb_t          wb_q, wb_d;
   logic             misalign_q, misalign_d;
   logic             bus_err_q, bus_err_d;

   logic             is_load, is_store;
   logic             size_h, size_w;
   logic             misaligned, access;
   logic             done, abort, timed_out;
   logic [31:0]      load_value;

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .addr   (mem_addr[1:0]),
      .funct3 (mem_funct3),
      .value  (load_value)
   );

   // Access decode and alignment.
   always_comb begin
      // read+write together is treated as a load
      is_load    = mem_read;
      is_store   = mem_write & ~mem_read;
      size_h     = (mem_funct3[1:0] == 2'b01);
      size_w     = (mem_funct3[1:0] == 2'b10);
      misaligned = mem_valid & (mem_read | mem_write) &
                   ((size_h & mem_addr[0]) | (size_w & (mem_addr[1:0] != 2'b00)));
      access     = mem_valid & (mem_read | mem_write) & ~misaligned;
      timed_out  = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
   end

   // Request side: address and lanes come straight from the held inputs.
   always_comb begin
      dmem_req   = access & ~reset & (state_q != RESP);
      dmem_we    = access & is_store;
      dmem_addr  = {mem_addr[XLEN-1:2], 2'b00};
      dmem_wstrb = 4'b0000;
      dmem_wdata = mem_wdata;
      if (is_store) begin
         case (mem_funct3[1:0])
            2'b00: begin
               dmem_wstrb = 4'b0001 << mem_addr[1:0];
               dmem_wdata = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
               dmem_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
               dmem_wdata = {2{mem_wdata[15:0]}};
            end
            default: dmem_wstrb = 4'hF;
         endcase
      end
   end

   // Handshake FSM next state. A handshake in the same cycle as the
   // timeout limit wins over the abort.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done    = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (dmem_gnt) begin
                  if (is_store) done = 1'b1;
                  else          state_d = RESP;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (dmem_gnt) begin
               if (is_store) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RESP;
               end
            end else if (timed_out) begin
               abort = 1'b1;
            end
         end
         RESP: begin
            // rvalid is only consumed here, i.e. after our own grant, so a
            // late rvalid from an aborted access is ignored in IDLE/REQ.
            if (dmem_rvalid) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (timed_out) begin
               abort = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;

      if (state_d == IDLE)      cnt_d = '0;
      else if (state_q != IDLE) cnt_d = cnt_q + 1'b1;
   end

   assign stall_o = access & ~done & ~abort;

   // MEM/WB capture: a result when the instruction leaves MEM, else a bubble.
   always_comb begin
      wb_d       = '0;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      if (mem_valid & ~stall_o) begin
         wb_d.valid    = 1'b1;
         wb_d.rd       = mem_rd;
         wb_d.regwrite = mem_regwrite & (mem_rd != 5'd0) & ~misaligned & ~abort;
         wb_d.data     = (mem_memtoreg & is_load & done) ? load_value : mem_addr;
         misalign_d    = misaligned;
         bus_err_d     = abort;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         wb_q       <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_q       <= wb_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign wb_valid    = wb_q.valid;
   assign wb_regwrite = wb_q.regwrite;
   assign wb_rd       = wb_q.rd;
   assign wb_data     = wb_q.data;
   assign misalign_o  = misalign_q;
   assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
module tb_mem_stage_lsu;

   localparam int T    = 8;
   localparam int HALF = 5;
   localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #HALF clk = ~clk;

   logic        mem_valid, mem_read, mem_write, mem_regwrite, mem_memtoreg;
   logic [31:0] mem_addr, mem_wdata;
   logic [2:0]  mem_funct3;
   logic [4:0]  mem_rd;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic        stall_o, misalign_o, bus_err_o;
   logic        wb_valid, wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   mem_stage_lsu #(.TIMEOUT_CYCLES(T), .XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_funct3(mem_funct3), .mem_read(mem_read), .mem_write(mem_write),
      .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
      .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   // ---------------- scoreboard ----------------
   // entry: {bus_err, misalign, chk_data, regwrite, rd[4:0], data[31:0]}
   logic [40:0] exp_q[$];
   logic [40:0] mon_e;
   int checks = 0;
   int errors = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                            input logic [2:0] f3);
      longint v;
      v = longint'(word) >> (8 * int'(off));
      case (f3)
         LB:  begin v = v % 256;   if (v > 127)   v = v - 256;   end
         LBU: v = v % 256;
         LH:  begin v = v % 65536; if (v > 32767) v = v - 65536; end
         LHU: v = v % 65536;
         default: v = longint'(word);
      endcase
      return v[31:0];
   endfunction

   function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] off);
      int s;
      case (f3[1:0])
         2'b00:   s = 1 << off;
         2'b01:   s = 3 << off;
         default: s = 15;
      endcase
      return s[3:0];
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {24'd0, wd[7:0]} * 32'h0101_0101;
         2'b01:   return {16'd0, wd[15:0]} * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset) begin
         if (wb_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected actual=valid rd=%0d data=%h required=none", wb_rd, wb_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e[36:32]});
               check("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, mon_e[37]});
               check("misalign_o", {31'd0, misalign_o}, {31'd0, mon_e[39]});
               check("bus_err_o", {31'd0, bus_err_o}, {31'd0, mon_e[40]});
               if (mon_e[38]) check("wb_data", wb_data, mon_e[31:0]);
            end
         end else begin
            check("bubble_regwrite", {31'd0, wb_regwrite}, 32'd0);
            check("bubble_misalign", {31'd0, misalign_o}, 32'd0);
            check("bubble_bus_err", {31'd0, bus_err_o}, 32'd0);
         end
      end
   end

   // ---------------- driver ----------------
   // g: cycle (from the instruction's first MEM cycle) in which gnt is given,
   //    -1 for never; r: cycles from gnt to rvalid, -1 for never.
   // Delays used here stay inside the timeout budget unless they are -1.
   task automatic issue(input logic v, input logic rd_i, input logic wr_i, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic regw,
                        input logic [4:0] rd, input int g, input int r, input logic [31:0] word);
      logic mis, acc, timeout, fin;
      int   done_k, stall_n, req_n;
      logic [31:0] data;
      mis = v && (rd_i || wr_i) &&
            ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00));
      acc = v && (rd_i || wr_i) && !mis;
      timeout = acc && (g < 0 || (rd_i && r < 0));
      done_k  = !acc ? 0 : timeout ? T : rd_i ? g + r : g;
      data    = (acc && rd_i && !timeout) ? ref_load(word, addr[1:0], f3) : addr;
      if (v)
         exp_q.push_back({timeout, mis, !mis && !timeout,
                          regw && rd != 5'd0 && !mis && !timeout, rd, data});

      mem_valid = v;  mem_read = rd_i;  mem_write = wr_i;  mem_funct3 = f3;
      mem_addr = addr;  mem_wdata = wd;  mem_regwrite = regw;
      mem_memtoreg = rd_i;  mem_rd = rd;
      stall_n = 0;  req_n = 0;  fin = 1'b0;
      for (int k = 0; k < 40 && !fin; k++) begin
         dmem_gnt    = acc && (k == g);
         dmem_rvalid = acc && rd_i && g >= 0 && r >= 0 && (k == g + r);
         dmem_rdata  = dmem_rvalid ? word : $urandom();
         @(negedge clk);
         if (dmem_req) begin
            req_n++;
            check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
            check("dmem_we", {31'd0, dmem_we}, {31'd0, !rd_i});
            if (rd_i) check("dmem_wstrb_ld", {28'd0, dmem_wstrb}, 32'd0);
            else begin
               check("dmem_wstrb", {28'd0, dmem_wstrb}, {28'd0, ref_strb(f3, addr[1:0])});
               check("dmem_wdata", dmem_wdata, ref_wdata(f3, wd));
            end
         end
         if (!stall_o) fin = 1'b1;
         else stall_n++;
         @(posedge clk);
         #1;
      end
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL stall_bound actual=still_stalled required=released addr=%h", addr);
      end
      check("stall_cycles", stall_n, done_k);
      if (!acc) check("req_cycles_none", req_n, 0);
      else if (!timeout) check("req_cycles", req_n, g + 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0]  f3s[5];
      logic [2:0]  f3;
      logic [31:0] a;
      int          kind;
      f3s = '{LB, LH, LW, LBU, LHU};

      // reset with a valid load presented: no request may be issued
      reset = 1'b1;
      mem_valid = 1'b1;  mem_read = 1'b1;  mem_write = 1'b0;  mem_funct3 = LW;
      mem_addr = 32'h0000_0100;  mem_wdata = '0;  mem_regwrite = 1'b1;
      mem_memtoreg = 1'b1;  mem_rd = 5'd1;
      dmem_gnt = 1'b1;  dmem_rvalid = 1'b0;  dmem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_req", {31'd0, dmem_req}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
      check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_misalign", {31'd0, misalign_o}, 32'd0);
      check("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_valid = 1'b0;
      dmem_gnt = 1'b0;

      // directed cases
      issue(1, 0, 1, LB,  32'h0000_1003, 32'h0000_00A5, 0, 5'd0, 0, -1, 32'h0);           // SB
      issue(1, 1, 0, LB,  32'h0000_2001, 32'h0,         1, 5'd7, 0, 1, 32'h1234_8056);    // LB
      issue(1, 1, 0, LBU, 32'h0000_2001, 32'h0,         1, 5'd8, 0, 1, 32'h1234_8056);    // LBU
      issue(1, 1, 0, LH,  32'h0000_3002, 32'h0,         1, 5'd9, 3, 2, 32'hBEEF_0000);    // LH
      issue(1, 1, 0, LW,  32'h0000_4001, 32'h0,         1, 5'd10, 0, 1, 32'h0);           // misaligned
      issue(1, 0, 1, LH,  32'h0000_4003, 32'h1234_5678, 0, 5'd0, 0, -1, 32'h0);           // SH misaligned
      issue(1, 0, 1, LH,  32'h0000_4002, 32'h1234_5678, 0, 5'd0, 1, -1, 32'h0);           // SH upper
      issue(1, 0, 0, LB,  32'h0000_0042, 32'h0,         1, 5'd0, 0, -1, 32'h0);           // ADD to x0
      issue(1, 1, 0, LW,  32'h0000_6000, 32'h0,         1, 5'd3, 0, -1, 32'h0);           // load timeout
      issue(1, 0, 1, LW,  32'h0000_6004, 32'h5555_AAAA, 0, 5'd0, -1, -1, 32'h0);          // store timeout
      issue(1, 1, 0, LW,  32'h0000_6008, 32'h0,         1, 5'd4, 0, 1, 32'hCAFE_F00D);    // after abort

      // reset while a request is pending and WB holds a valid result
      issue(1, 0, 0, LB, 32'h1234_5678, 32'h0, 1, 5'd9, 0, -1, 32'h0);
      mem_valid = 1'b1;  mem_read = 1'b1;  mem_write = 1'b0;  mem_funct3 = LW;
      mem_addr = 32'h0000_5000;  mem_memtoreg = 1'b1;  mem_rd = 5'd2;
      @(negedge clk);
      #1;
      check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
      check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("mid_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      check("mid_rst_wb_data", wb_data, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // reset while waiting for rvalid
      mem_addr = 32'h0000_7000;  mem_rd = 5'd4;  dmem_gnt = 1'b1;
      @(negedge clk);
      check("resp_gnt_stall", {31'd0, stall_o}, 32'd1);
      @(posedge clk);
      #1;
      dmem_gnt = 1'b0;
      @(negedge clk);
      check("resp_req_low", {31'd0, dmem_req}, 32'd0);
      #1;
      reset = 1'b1;
      #1;
      check("resp_rst_req", {31'd0, dmem_req}, 32'd0);
      check("resp_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("resp_rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
      check("resp_rst_wb_data", wb_data, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      issue(1, 0, 0, LB, 32'hCAFE_0010, 32'h0, 1, 5'd12, 0, -1, 32'h0);                  // ADD
      issue(1, 1, 0, LHU, 32'h0000_8002, 32'h0, 1, 5'd13, 0, 1, 32'h8001_7FFF);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         a = $urandom();
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         case (kind)
            0, 1: issue(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), LW, a, $urandom(),
                        1, 5'($urandom_range(0, 31)), 0, 1, $urandom());
            2, 3: issue(1, 0, 0, 3'($urandom_range(0, 7)), a, $urandom(), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 31)), 0, -1, 32'h0);
            4, 5, 6: begin
               f3 = f3s[$urandom_range(0, 4)];
               if (f3 != LB && f3 != LBU && $urandom_range(0, 1) == 1) a[0] = 1'b0;
               issue(1, 1, 0, f3, a, $urandom(), 1'($urandom_range(0, 3) != 0),
                     5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(1, 3), $urandom());
            end
            7, 8: begin
               f3 = 3'($urandom_range(0, 2));
               issue(1, 0, 1, f3, a, $urandom(), 0, 5'($urandom_range(0, 31)),
                     $urandom_range(0, 3), -1, 32'h0);
            end
            default: begin
               f3 = f3s[$urandom_range(0, 4)];
               issue(1, 1, 1, f3, a, $urandom(), 1, 5'($urandom_range(1, 31)),
                     $urandom_range(0, 3), $urandom_range(1, 3), $urandom());
            end
         endcase
      end

      issue(0, 0, 0, LB, 32'h0, 32'h0, 0, 5'd0, 0, -1, 32'h0);
      issue(0, 0, 0, LB, 32'h0, 32'h0, 0, 5'd0, 0, -1, 32'h0);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
